// File: rtl/crc5_check_if.sv
// Token-body bus between the bit unstuffer, the CRC5 checker and the packet decoder.
// The unstuffer drives the serial side; the checker drives the verdict side.
interface crc5_check_if;
  logic       s_in;
  logic       start;
  logic       endr;
  logic       pause;
  logic       done;
  logic       crc_ok;
  logic       len_err;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       busy;

  modport master (
    output s_in, start, endr, pause,
    input  done, crc_ok, len_err, addr, endp, busy
  );

  modport slave (
    input  s_in, start, endr, pause,
    output done, crc_ok, len_err, addr, endp, busy
  );
endinterface

// File: rtl/crc5_check.sv
// USB token CRC5 checker: runs the x^5+x^2+1 LFSR over the de-stuffed token body,
// captures ADDR/ENDP and issues a registered one-cycle verdict at the end of the body.
module crc5_check #(
  parameter int unsigned NBITS   = 16,
  parameter logic [4:0]  RESIDUE = 5'b01100,
  parameter int unsigned PAYLOAD = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  crc5_check_if.slave  tok
);

  localparam logic [4:0] LP_NBITS   = 5'(NBITS);
  localparam logic [4:0] LP_PAYLOAD = 5'(PAYLOAD);

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_crc;
  logic [4:0] r_cnt;
  logic [6:0] r_addr;
  logic [3:0] r_endp;
  logic       r_done;
  logic       r_crc_ok;
  logic       r_len_err;

  logic       w_take;
  logic       w_verdict;
  logic [4:0] w_seed;
  logic       w_fb;
  logic [4:0] w_crc_nxt;
  logic [4:0] w_cnt_base;
  logic [4:0] w_cnt_nxt;
  logic [1:0] w_eidx;
  logic [6:0] w_addr_nxt;
  logic [3:0] w_endp_nxt;

  // Datapath for the bit on s_in; a start bit restarts from the seed and bit index 0.
  always_comb begin
    w_seed     = tok.start ? 5'b11111 : r_crc;
    w_fb       = w_seed[4] ^ tok.s_in;
    w_crc_nxt  = {w_seed[3:0], 1'b0} ^ (w_fb ? 5'b00101 : 5'b00000);
    w_cnt_base = tok.start ? '0 : r_cnt;
    w_cnt_nxt  = (w_cnt_base == '1) ? '1 : w_cnt_base + 5'd1;
    w_eidx     = 2'(w_cnt_base - 5'd7);
    w_addr_nxt = tok.start ? '0 : r_addr;
    w_endp_nxt = tok.start ? '0 : r_endp;
    if (w_cnt_base < 5'd7) begin
      w_addr_nxt[w_cnt_base[2:0]] = tok.s_in;
    end else if (w_cnt_base < LP_PAYLOAD) begin
      w_endp_nxt[w_eidx] = tok.s_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_verdict   = 1'b0;
    if (!tok.pause) begin
      if (tok.start) begin
        w_take      = 1'b1;
        w_verdict   = tok.endr;
        w_state_nxt = tok.endr ? ST_IDLE : ST_RECV;
      end else if (r_state == ST_RECV) begin
        w_take = 1'b1;
        if (tok.endr) begin
          w_verdict   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc     <= 5'b11111;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_endp    <= '0;
      r_done    <= 1'b0;
      r_crc_ok  <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_done <= w_verdict;
      if (w_take) begin
        r_crc  <= w_crc_nxt;
        r_cnt  <= w_cnt_nxt;
        r_addr <= w_addr_nxt;
        r_endp <= w_endp_nxt;
      end
      if (w_verdict) begin
        r_len_err <= (w_cnt_nxt != LP_NBITS);
        r_crc_ok  <= (w_cnt_nxt == LP_NBITS) && (w_crc_nxt == RESIDUE);
      end
    end
  end

  assign tok.done    = r_done;
  assign tok.crc_ok  = r_crc_ok;
  assign tok.len_err = r_len_err;
  assign tok.addr    = r_addr;
  assign tok.endp    = r_endp;
  assign tok.busy    = (r_state == ST_RECV);

endmodule

// File: tb/tb_crc5_check.sv
// Randomised scoreboard bench for crc5_check; the reference residue is computed
// by polynomial long division of the whole received bit string.
module tb_crc5_check;

  typedef bit bq_t[$];

  typedef struct {
    int unsigned cyc;
    logic        ok;
    logic        le;
    bit          chk_ae;
    logic [6:0]  a;
    logic [3:0]  e;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned total;
  int unsigned bad;
  exp_t sb[$];
  bit   m_active;
  bq_t  m_bits;

  crc5_check_if tok ();

  crc5_check #(
    .NBITS  (16),
    .RESIDUE(5'b01100),
    .PAYLOAD(11)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tok  (tok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Remainder of (11111 * x^n + M(x) * x^5) mod x^5+x^2+1, bit 0 of the string is the highest term.
  function automatic logic [4:0] model_res(input bq_t b);
    bit d [0:127];
    int n;
    n = b.size();
    for (int k = 0; k < 128; k++) d[k] = 1'b0;
    for (int k = 0; k < 5; k++) d[n + k] ^= 1'b1;
    for (int i = 0; i < n; i++) d[n + 4 - i] ^= b[i];
    for (int g = n + 4; g >= 5; g--) begin
      if (d[g]) begin
        d[g]     = 1'b0;
        d[g - 3] ^= 1'b1;
        d[g - 5] ^= 1'b1;
      end
    end
    return {d[4], d[3], d[2], d[1], d[0]};
  endfunction

  function automatic bq_t payload(input logic [6:0] a, input logic [3:0] e);
    bq_t q;
    for (int i = 0; i < 7; i++) q.push_back(a[i]);
    for (int i = 0; i < 4; i++) q.push_back(e[i]);
    return q;
  endfunction

  function automatic bq_t with_crc(input bq_t p, input logic [4:0] c);
    bq_t q;
    q = p;
    for (int i = 4; i >= 0; i--) q.push_back(c[i]);
    return q;
  endfunction

  function automatic bq_t good_token(input logic [6:0] a, input logic [3:0] e);
    bq_t p;
    bq_t q;
    p = payload(a, e);
    q = with_crc(p, 5'b00000);
    for (int c = 0; c < 32; c++) begin
      q = with_crc(p, 5'(c));
      if (model_res(q) == 5'b01100) return q;
    end
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_expect();
    exp_t x;
    int unsigned len;
    len      = (m_bits.size() > 31) ? 31 : m_bits.size();
    x.cyc    = cyc + 1;
    x.le     = (len != 16);
    x.ok     = !x.le && (model_res(m_bits) == 5'b01100);
    x.chk_ae = (m_bits.size() >= 11);
    x.a      = '0;
    x.e      = '0;
    if (x.chk_ae) begin
      for (int i = 0; i < 7; i++) x.a[i] = m_bits[i];
      for (int i = 0; i < 4; i++) x.e[i] = m_bits[7 + i];
    end
    sb.push_back(x);
  endtask

  task automatic drive(input bit b, input bit st, input bit en, input bit pz);
    @(negedge clk);
    tok.s_in  = b;
    tok.start = st;
    tok.endr  = en;
    tok.pause = pz;
    if (!pz) begin
      if (st) begin
        m_active = 1'b1;
        m_bits   = {};
      end
      if (m_active) begin
        m_bits.push_back(b);
        if (en) begin
          push_expect();
          m_active = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(tok.busy), 32'(m_active));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // Sends q with start on bit 0 and endr on bit endat (-1: none); pz_after[i] adds a garbage pause cycle after bit i.
  task automatic send(input bq_t q, input int endat, input logic [63:0] pz_after, input int rnd_pause);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i], i == 0, i == endat, 1'b0);
      if (pz_after[i] || (rnd_pause > 0 && $urandom_range(rnd_pause - 1, 0) == 0))
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".done"},    32'(tok.done),    32'd0);
    check({tag, ".crc_ok"},  32'(tok.crc_ok),  32'd0);
    check({tag, ".len_err"}, 32'(tok.len_err), 32'd0);
    check({tag, ".addr"},    32'(tok.addr),    32'd0);
    check({tag, ".endp"},    32'(tok.endp),    32'd0);
    check({tag, ".busy"},    32'(tok.busy),    32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL done_missing: no done at cycle %0d, expected one", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (tok.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: done=1 at cycle %0d, expected 0", cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("done_cycle", cyc, x.cyc);
          check("crc_ok", 32'(tok.crc_ok), 32'(x.ok));
          check("len_err", 32'(tok.len_err), 32'(x.le));
          if (x.chk_ae) begin
            check("addr", 32'(tok.addr), 32'(x.a));
            check("endp", 32'(tok.endp), 32'(x.e));
          end
        end
      end
    end
  end

  initial begin
    bq_t q;
    bq_t r;
    cyc       = 0;
    total     = 0;
    bad       = 0;
    m_active  = 1'b0;
    tok.s_in  = 1'b0;
    tok.start = 1'b0;
    tok.endr  = 1'b0;
    tok.pause = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Known token: addr 15h, endp Eh, CRC 10111 MSB first.
    q = with_crc(payload(7'h15, 4'hE), 5'b10111);
    send(q, 15, '0, 0);
    idle(3);

    // Single-bit corruptions: bit 9 and each CRC bit.
    r = q; r[9] = ~r[9];
    send(r, 15, '0, 0);
    idle(2);
    for (int k = 11; k < 16; k++) begin
      r = q; r[k] = ~r[k];
      send(r, 15, '0, 0);
      idle(1);
    end

    // Pauses with garbage after bits 3, 5 and 15.
    send(q, 15, 64'h0000_0000_0000_8028, 0);
    idle(2);

    // Length errors: 15, 17 and 40 bits.
    send(q, 14, '0, 0);
    idle(2);
    r = q; r.push_back(1'b0);
    send(r, 16, '0, 0);
    idle(2);
    r = {};
    for (int i = 0; i < 40; i++) r.push_back(1'($urandom));
    send(r, 39, '0, 0);
    idle(2);

    // Restart at bit 6, then a full good token.
    r = {};
    for (int i = 0; i < 6; i++) r.push_back(q[i]);
    send(r, -1, '0, 0);
    send(q, 15, '0, 0);
    idle(2);

    // Stray endr in IDLE and a start+endr one-bit packet.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Asynchronous reset at bit 8 of a packet.
    send(good_token(7'h5A, 4'h3), 15, '0, 0);
    idle(2);
    r = {};
    for (int i = 0; i < 8; i++) r.push_back(q[i]);
    send(r, -1, '0, 0);
    @(negedge clk);
    tok.s_in  = q[8];
    tok.start = 1'b0;
    tok.endr  = 1'b0;
    #2;
    rst_n    = 1'b0;
    m_active = 1'b0;
    #1;
    check_cleared("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send(q, 15, '0, 0);
    idle(2);

    // Random tokens with random corruption, lengths and pauses.
    for (int it = 0; it < 40; it++) begin
      int unsigned kind;
      kind = $urandom_range(9, 0);
      r = good_token(7'($urandom), 4'($urandom));
      if (kind == 0) begin
        r = {};
        for (int i = 0; i < int'($urandom_range(40, 1)); i++) r.push_back(1'($urandom));
      end else if (kind == 1) begin
        r.push_back(1'($urandom));
      end else if (kind == 2) begin
        void'(r.pop_back());
      end else if (kind < 5) begin
        int unsigned f;
        f = $urandom_range(15, 0);
        r[f] = ~r[f];
      end
      send(r, r.size() - 1, '0, 4);
      idle(int'($urandom_range(2, 0)));
    end

    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
